aux_bram_wr_master: RTL and testbench
=====================================

Name: aux_bram_wr_master

Overview:
- Write-side initiator for the auxiliary on-chip BRAM slave.
- Accepts one transfer descriptor (start byte address, total beat count) and pulls data beats from an upstream valid/ready stream.
- Splits the transfer into bursts of at most 2^LOG2_BURST beats and emits a command word followed by that burst's data words on the wr_req_vld/wr_req_pd bus.
- Flags the final burst as "last", waits for wr_complete, then pulses done.

Parameters:
- DATA_W, 256: data beat width in bits (MAX_DAT_DW*Tout); must be a power of two, at least 64.
- LOG2_BURST, 4: width of the burst length field; the largest burst is 2^LOG2_BURST beats.
- PD_W, 2+LOG2_BURST+32+DATA_W: width of wr_req_pd (derived; do not override).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  descriptor strobe; sampled only in IDLE
- start_addr  in  32  first byte address of the transfer
- total_beats  in  32  number of DATA_W beats in the transfer
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at transfer completion
- in_vld  in  1  upstream data valid
- in_rdy  out  1  upstream data ready
- in_dat  in  DATA_W  upstream data
- wr_req_vld  out  1  request word valid; the slave has no backpressure
- wr_req_pd  out  PD_W  request word (command or data)
- wr_complete  in  1  slave pulse: final data beat of the last burst has been written

Behaviour:
- Reset values: busy=0, done=0, in_rdy=0, wr_req_vld=0, wr_req_pd=0, state=IDLE. All internal counters are cleared.
- Command word format:
  - pd[PD_W-1]=1
  - pd[32+LOG2_BURST]=last
  - pd[32+LOG2_BURST-1:32]=beats-1
  - pd[31:0]=byte address
  - all other bits 0
- Data word format: pd[PD_W-1]=0, pd[DATA_W-1:0]=data, all other bits 0.
- wr_req_vld and wr_req_pd are registered. At most one word is issued per cycle. wr_req_pd is 0 in any cycle where wr_req_vld=0.
- States: IDLE, CMD, DATA, WAIT_CMPL.
- IDLE:
  - start=1 with total_beats>0: latch addr=start_addr and remaining=total_beats, then go to CMD.
  - start=1 with total_beats=0: pulse done on the next cycle. No bus traffic; stay in IDLE.
- CMD (exactly one cycle):
  - beats = min(remaining, 2^LOG2_BURST).
  - last = (remaining <= 2^LOG2_BURST).
  - Register the command word (wr_req_vld=1 in the following cycle).
  - Clear the beat counter and go to DATA.
- DATA:
  - in_rdy = (state==DATA), combinational from state.
  - Each in_vld&in_rdy registers one data word. A beat accepted at edge E appears on wr_req during the cycle after E.
  - Upstream gaps (in_vld=0) produce wr_req_vld=0 cycles; no filler words are sent.
  - When the beat counter reaches beats-1 and a beat is accepted:
    - if last: go to WAIT_CMPL;
    - else: addr += beats*(DATA_W/8) (mod 2^32), remaining -= beats, go to CMD.
  - in_rdy drops in the same edge as the transition.
- WAIT_CMPL:
  - wr_complete=1: done=1 in the next cycle, then go to IDLE.
  - wr_complete seen in any other state is ignored.
- start while busy is ignored; the descriptor is not queued.
- Minimum command-to-command spacing is beats+1 cycles. The slave always observes the command before its data.
- Reset mid-transfer: everything returns to reset values immediately. Any partial burst is abandoned and the slave is left to be reset alongside.

Optional Feature:
- Macro: AUX_WR_TIMEOUT_EN.
- With AUX_WR_TIMEOUT_EN:
  - Add output timeout (1 bit, reset 0) and parameter TIMEOUT_CYC (default 1024).
  - A 16-bit counter runs in WAIT_CMPL. If it reaches TIMEOUT_CYC with no wr_complete: timeout pulses for 1 cycle, done pulses in the same cycle, and the state returns to IDLE.
  - The counter clears on leaving WAIT_CMPL.
- Without AUX_WR_TIMEOUT_EN: no timeout port; WAIT_CMPL waits indefinitely.

Test Plan:
- LOG2_BURST=4, start_addr=0x100, total_beats=5, in_vld always 1:
  - one cmd word: last=1, len=4, addr=0x100;
  - then 5 data words on consecutive cycles matching in_dat;
  - wr_complete pulse -> done 1 cycle later; busy=0 after.
- total_beats=40, DATA_W=256, start_addr=0x0:
  - 3 cmd words: (addr 0x0, len 15, last 0), (addr 0x200, len 15, last 0), (addr 0x400, len 7, last 1);
  - 40 data words in order.
- total_beats=3 with in_vld toggling 1,0,0,1,1:
  - wr_req_vld follows one cycle later with the same gaps;
  - data order is preserved; no extra words.
- total_beats=0 -> done the next cycle, wr_req_vld stays 0. A start pulse asserted mid-transfer is ignored and produces no second command.
- rst_n asserted during DATA after beat 2 of 16 -> wr_req_vld=0, busy=0 and in_rdy=0 immediately. A new start after release begins a fresh cmd.
- With AUX_WR_TIMEOUT_EN and TIMEOUT_CYC=8, wr_complete withheld -> timeout and done both pulse 8 cycles after entering WAIT_CMPL.

Source files
------------

// File: rtl/aux_bram_wr_master.sv
// Write initiator for the auxiliary BRAM slave: splits one descriptor into bursts of
// command + data words. Optional completion watchdog under AUX_WR_TIMEOUT_EN.
module aux_bram_wr_master #(
   parameter int DATA_W     = 256,
   parameter int LOG2_BURST = 4,
   parameter int PD_W       = 2 + LOG2_BURST + 32 + DATA_W
`ifdef AUX_WR_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = 1024
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [31:0]       start_addr,
   input  logic [31:0]       total_beats,
   output logic              busy,
   output logic              done,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [DATA_W-1:0] in_dat,
   output logic              wr_req_vld,
   output logic [PD_W-1:0]   wr_req_pd,
   input  logic              wr_complete
`ifdef AUX_WR_TIMEOUT_EN
   , output logic            timeout
`endif
);

   localparam int          BW    = LOG2_BURST + 1;
   localparam logic [31:0] BURST = 32'(1) << LOG2_BURST;
   localparam int          BSH   = $clog2(DATA_W / 8);

   typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_CMPL} state_t;

   state_t                state_q;
   logic [31:0]           addr_q;
   logic [31:0]           remaining_q;
   logic [BW-1:0]         beats_q;
   logic                  last_q;
   logic [LOG2_BURST-1:0] cnt_q;
   logic                  wr_req_vld_q;
   logic [PD_W-1:0]       wr_req_pd_q;
   logic                  done_q;
`ifdef AUX_WR_TIMEOUT_EN
   logic [15:0]           tmo_cnt_q;
   logic                  timeout_q;
`endif

   logic [BW-1:0]         beats_d;
   logic                  last_d;
   logic                  last_beat_d;
   logic [PD_W-1:0]       cmd_pd_d;
   logic [PD_W-1:0]       dat_pd_d;

   always_comb begin
      beats_d     = (remaining_q > BURST) ? BURST[BW-1:0] : remaining_q[BW-1:0];
      last_d      = (remaining_q <= BURST);
      last_beat_d = ({1'b0, cnt_q} == (beats_q - BW'(1)));
      cmd_pd_d                       = '0;
      cmd_pd_d[PD_W-1]               = 1'b1;
      cmd_pd_d[32+LOG2_BURST]        = last_d;
      cmd_pd_d[32 +: LOG2_BURST]     = LOG2_BURST'(beats_d - BW'(1));
      cmd_pd_d[31:0]                 = addr_q;
      dat_pd_d                       = '0;
      dat_pd_d[DATA_W-1:0]           = in_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         remaining_q  <= '0;
         beats_q      <= '0;
         last_q       <= 1'b0;
         cnt_q        <= '0;
         wr_req_vld_q <= 1'b0;
         wr_req_pd_q  <= '0;
         done_q       <= 1'b0;
`ifdef AUX_WR_TIMEOUT_EN
         tmo_cnt_q    <= '0;
         timeout_q    <= 1'b0;
`endif
      end else begin
         // Bus word and pulses are single-cycle unless re-issued below.
         wr_req_vld_q <= 1'b0;
         wr_req_pd_q  <= '0;
         done_q       <= 1'b0;
`ifdef AUX_WR_TIMEOUT_EN
         timeout_q    <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (total_beats != '0) begin
                     addr_q      <= start_addr;
                     remaining_q <= total_beats;
                     state_q     <= CMD;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            CMD: begin
               wr_req_vld_q <= 1'b1;
               wr_req_pd_q  <= cmd_pd_d;
               beats_q      <= beats_d;
               last_q       <= last_d;
               cnt_q        <= '0;
               state_q      <= DATA;
            end
            DATA: begin
               if (in_vld) begin
                  wr_req_vld_q <= 1'b1;
                  wr_req_pd_q  <= dat_pd_d;
                  cnt_q        <= cnt_q + LOG2_BURST'(1);
                  if (last_beat_d) begin
                     if (last_q) begin
                        state_q <= WAIT_CMPL;
                     end else begin
                        addr_q      <= addr_q + (32'(beats_q) << BSH);
                        remaining_q <= remaining_q - 32'(beats_q);
                        state_q     <= CMD;
                     end
                  end
               end
            end
            WAIT_CMPL: begin
`ifdef AUX_WR_TIMEOUT_EN
               if (wr_complete) begin
                  done_q    <= 1'b1;
                  tmo_cnt_q <= '0;
                  state_q   <= IDLE;
               end else if (tmo_cnt_q == 16'(TIMEOUT_CYC - 1)) begin
                  done_q    <= 1'b1;
                  timeout_q <= 1'b1;
                  tmo_cnt_q <= '0;
                  state_q   <= IDLE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 16'd1;
               end
`else
               if (wr_complete) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy       = (state_q != IDLE);
   assign in_rdy     = (state_q == DATA);
   assign done       = done_q;
   assign wr_req_vld = wr_req_vld_q;
   assign wr_req_pd  = wr_req_pd_q;
`ifdef AUX_WR_TIMEOUT_EN
   assign timeout    = timeout_q;
`endif

endmodule

// File: tb/tb_aux_bram_wr_master.sv
// Directed bench for aux_bram_wr_master (DATA_W=256, LOG2_BURST=4).
module tb_aux_bram_wr_master;
   localparam int DATA_W     = 256;
   localparam int LOG2_BURST = 4;
   localparam int PD_W       = 2 + LOG2_BURST + 32 + DATA_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [31:0]       start_addr = '0;
   logic [31:0]       total_beats = '0;
   logic              busy, done, in_rdy, wr_req_vld;
   logic              in_vld = 1'b0;
   logic [DATA_W-1:0] in_dat = '0;
   logic [PD_W-1:0]   wr_req_pd;
   logic              wr_complete = 1'b0;
`ifdef AUX_WR_TIMEOUT_EN
   logic              timeout;
`endif

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int bad_idle = 0;
   logic [PD_W-1:0] cap_pd[$];
   int              cap_cyc[$];
   logic [PD_W-1:0] exp_pd[$];

   aux_bram_wr_master #(
      .DATA_W(DATA_W),
      .LOG2_BURST(LOG2_BURST)
`ifdef AUX_WR_TIMEOUT_EN
      , .TIMEOUT_CYC(8)
`endif
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
      .total_beats(total_beats), .busy(busy), .done(done),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
      .wr_req_vld(wr_req_vld), .wr_req_pd(wr_req_pd), .wr_complete(wr_complete)
`ifdef AUX_WR_TIMEOUT_EN
      , .timeout(timeout)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_req_vld) begin
            cap_pd.push_back(wr_req_pd);
            cap_cyc.push_back(cyc);
         end else if (wr_req_pd != '0) begin
            bad_idle <= bad_idle + 1;
         end
      end
   end

   function automatic logic [DATA_W-1:0] pat(int k);
      logic [DATA_W-1:0] p;
      for (int i = 0; i < DATA_W / 32; i++) p[32*i +: 32] = 32'hC0DE_0000 + 32'(k * 16 + i);
      return p;
   endfunction

   function automatic logic [PD_W-1:0] mk_cmd(logic [31:0] a, int lenm1, bit last);
      logic [PD_W-1:0] r;
      r = '0;
      r[PD_W-1] = 1'b1;
      r[32+LOG2_BURST] = last;
      r[32 +: LOG2_BURST] = LOG2_BURST'(lenm1);
      r[31:0] = a;
      return r;
   endfunction

   function automatic logic [PD_W-1:0] mk_dat(int k);
      logic [PD_W-1:0] r;
      r = '0;
      r[DATA_W-1:0] = pat(k);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [PD_W-1:0] obs, logic [PD_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Feeds n beats (pattern base..base+n-1); vmask gives in_vld per in_rdy cycle.
   task automatic feed(int base, int n, logic [7:0] vmask, int plen, bit poke, int maxcyc);
      int k = 0;
      int pidx = 0;
      int t = 0;
      bit acc;
      while (k < n && t < maxcyc) begin
         in_vld = in_rdy ? vmask[pidx % plen] : 1'b0;
         in_dat = pat(base + k);
         start  = (poke && t == 2);
         total_beats = start ? 32'd9 : total_beats;
         acc = in_vld && in_rdy;
         if (in_rdy) pidx++;
         step();
         if (acc) k++;
         t++;
      end
      in_vld = 1'b0;
      start  = 1'b0;
      chk("feed_beats", PD_W'(k), PD_W'(n));
   endtask

   task automatic begin_xfer(logic [31:0] a, int n);
      start = 1'b1;
      start_addr = a;
      total_beats = 32'(n);
      step();
      start = 1'b0;
   endtask

   task automatic complete();
      chk("wait_busy", PD_W'(busy), PD_W'(1));
      wr_complete = 1'b1;
      step();
      wr_complete = 1'b0;
      chk("done_pulse", PD_W'(done), PD_W'(1));
      chk("busy_after", PD_W'(busy), PD_W'(0));
      step();
      chk("done_clear", PD_W'(done), PD_W'(0));
   endtask

   task automatic cmp_words(string tag);
      chk({tag, "_count"}, PD_W'(cap_pd.size()), PD_W'(exp_pd.size()));
      for (int i = 0; i < exp_pd.size() && i < cap_pd.size(); i++) chk(tag, cap_pd[i], exp_pd[i]);
   endtask

   initial begin
      // Reset state
      step(); step();
      chk("rst_busy", PD_W'(busy), PD_W'(0));
      chk("rst_done", PD_W'(done), PD_W'(0));
      chk("rst_in_rdy", PD_W'(in_rdy), PD_W'(0));
      chk("rst_vld", PD_W'(wr_req_vld), PD_W'(0));
      chk("rst_pd", wr_req_pd, '0);
      rst_n = 1'b1;
      step();

      // 5 beats, single burst, continuous valid
      cap_pd.delete(); cap_cyc.delete(); exp_pd.delete();
      begin_xfer(32'h100, 5);
      feed(0, 5, 8'h01, 1, 1'b0, 50);
      step();
      exp_pd.push_back(mk_cmd(32'h100, 4, 1'b1));
      for (int i = 0; i < 5; i++) exp_pd.push_back(mk_dat(i));
      cmp_words("t1_word");
      if (cap_cyc.size() == 6) begin
         chk("t1_first_gap", PD_W'(cap_cyc[1] - cap_cyc[0]), PD_W'(1));
         chk("t1_span", PD_W'(cap_cyc[5] - cap_cyc[0]), PD_W'(5));
      end
      complete();

      // 40 beats -> three bursts
      cap_pd.delete(); cap_cyc.delete(); exp_pd.delete();
      begin_xfer(32'h0, 40);
      feed(100, 40, 8'h01, 1, 1'b0, 200);
      step();
      for (int i = 0; i < 40; i++) begin
         if (i == 0)  exp_pd.push_back(mk_cmd(32'h000, 15, 1'b0));
         if (i == 16) exp_pd.push_back(mk_cmd(32'h200, 15, 1'b0));
         if (i == 32) exp_pd.push_back(mk_cmd(32'h400, 7, 1'b1));
         exp_pd.push_back(mk_dat(100 + i));
      end
      cmp_words("t2_word");
      complete();

      // 3 beats with gapped valid 1,0,0,1,1 and a start pulse while busy
      cap_pd.delete(); cap_cyc.delete(); exp_pd.delete();
      begin_xfer(32'h3000, 3);
      feed(200, 3, 8'b11001, 5, 1'b1, 50);
      step();
      exp_pd.push_back(mk_cmd(32'h3000, 2, 1'b1));
      for (int i = 0; i < 3; i++) exp_pd.push_back(mk_dat(200 + i));
      cmp_words("t3_word");
      if (cap_cyc.size() == 4) begin
         chk("t3_gap1", PD_W'(cap_cyc[1] - cap_cyc[0]), PD_W'(1));
         chk("t3_gap2", PD_W'(cap_cyc[2] - cap_cyc[0]), PD_W'(4));
         chk("t3_gap3", PD_W'(cap_cyc[3] - cap_cyc[0]), PD_W'(5));
      end
      complete();
      step(); step(); step();
      chk("t3_no_second_cmd", PD_W'(cap_pd.size()), PD_W'(4));
      chk("t3_idle", PD_W'(busy), PD_W'(0));

      // total_beats = 0
      cap_pd.delete(); cap_cyc.delete();
      begin_xfer(32'h500, 0);
      chk("zero_done", PD_W'(done), PD_W'(1));
      chk("zero_busy", PD_W'(busy), PD_W'(0));
      step();
      chk("zero_done_clear", PD_W'(done), PD_W'(0));
      step();
      chk("zero_no_words", PD_W'(cap_pd.size()), PD_W'(0));

      // Reset mid-burst after beat 2 of 16
      begin_xfer(32'h40, 16);
      feed(300, 2, 8'h01, 1, 1'b0, 50);
      chk("pre_rst_vld", PD_W'(wr_req_vld), PD_W'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", PD_W'(wr_req_vld), PD_W'(0));
      chk("mid_rst_busy", PD_W'(busy), PD_W'(0));
      chk("mid_rst_in_rdy", PD_W'(in_rdy), PD_W'(0));
      step(); step();
      rst_n = 1'b1;
      cap_pd.delete(); cap_cyc.delete(); exp_pd.delete();
      step();
      begin_xfer(32'h80, 2);
      feed(400, 2, 8'h01, 1, 1'b0, 50);
      step();
      exp_pd.push_back(mk_cmd(32'h80, 1, 1'b1));
      exp_pd.push_back(mk_dat(400));
      exp_pd.push_back(mk_dat(401));
      cmp_words("t5_word");
      complete();

`ifdef AUX_WR_TIMEOUT_EN
      // Completion withheld -> watchdog fires 8 cycles into WAIT_CMPL
      begin_xfer(32'h900, 1);
      feed(500, 1, 8'h01, 1, 1'b0, 50);
      for (int i = 0; i < 7; i++) begin
         step();
         chk("tmo_early", PD_W'(timeout), PD_W'(0));
      end
      step();
      chk("tmo_pulse", PD_W'(timeout), PD_W'(1));
      chk("tmo_done", PD_W'(done), PD_W'(1));
      chk("tmo_busy", PD_W'(busy), PD_W'(0));
      step();
      chk("tmo_clear", PD_W'(timeout), PD_W'(0));
`endif

      chk("idle_pd_zero", PD_W'(bad_idle), PD_W'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
